// File: rtl/usb_d_orig_gen.sv
// usb_d_orig_gen: USB transmit line encoder (LSB-first serialiser, bit stuffing, NRZI).
// Define D_ORIG_GEN_EOP_EN to emit an SE0/SE0/J end-of-packet; otherwise the line returns straight to J.
module usb_d_orig_gen #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sending,
    input  logic [7:0] data,
    output logic       d_plus,
    output logic       d_minus
);
`ifdef D_ORIG_GEN_EOP_EN
    typedef enum logic [1:0] {IDLE, SEND, EOP_SE0, EOP_J} state_t;
    localparam logic [8:0] EOP_LAST = 9'(2 * CLKS_PER_BIT - 1);
`else
    typedef enum logic {IDLE, SEND} state_t;
`endif
    localparam logic [8:0] BIT_LAST = 9'(CLKS_PER_BIT - 1);
    localparam logic [7:0] ONES_MAX = 8'(STUFF_LIMIT);

    state_t     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] ones_q, ones_d;
    logic       dp_q, dp_d, dm_q, dm_d;
    logic       tx, nb;
    logic [7:0] ones_base;

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            ones_q  <= '0;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            ones_q  <= ones_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sr_d      = sr_q;
        ones_d    = ones_q;
        dp_d      = dp_q;
        dm_d      = dm_q;
        tx        = 1'b0;
        nb        = 1'b0;
        ones_base = ones_q;
        case (state_q)
            IDLE: begin
                dp_d = 1'b1;
                dm_d = 1'b0;
                if (sending) begin
                    state_d   = SEND;
                    sr_d      = data;
                    bit_d     = '0;
                    cnt_d     = '0;
                    tx        = 1'b1;
                    nb        = data[0];
                    ones_base = '0;
                end
            end
            SEND: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    // A pending stuff bit freezes the byte position so it also precedes the next byte or EOP
                    if (ones_q == ONES_MAX) begin
                        tx = 1'b1;
                        nb = 1'b0;
                    end else if (bit_q != 3'd7) begin
                        sr_d  = {sr_q[0], sr_q[7:1]};
                        bit_d = bit_q + 3'd1;
                        tx    = 1'b1;
                        nb    = sr_q[1];
                    end else if (sending) begin
                        sr_d  = data;
                        bit_d = '0;
                        tx    = 1'b1;
                        nb    = data[0];
                    end else begin
`ifdef D_ORIG_GEN_EOP_EN
                        state_d = EOP_SE0;
                        dp_d    = 1'b0;
                        dm_d    = 1'b0;
`else
                        state_d = IDLE;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
`endif
                    end
                end
            end
`ifdef D_ORIG_GEN_EOP_EN
            EOP_SE0: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == EOP_LAST) begin
                    cnt_d   = '0;
                    state_d = EOP_J;
                    dp_d    = 1'b1;
                    dm_d    = 1'b0;
                end
            end
            EOP_J: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // NRZI: a 0 toggles J<->K, a 1 holds the line
        if (tx) begin
            dp_d   = nb ? dp_q : ~dp_q;
            dm_d   = nb ? dm_q : ~dm_q;
            ones_d = nb ? ones_base + 8'd1 : 8'd0;
        end
    end

    assign d_plus  = dp_q;
    assign d_minus = dm_q;
endmodule

// File: tb/tb_usb_d_orig_gen.sv
// tb_usb_d_orig_gen: randomized packets checked cycle-by-cycle against a line-level reference model via a scoreboard queue.
module tb_usb_d_orig_gen;
    localparam int CPB = 8;
    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       sending = 1'b0;
    logic [7:0] data = 8'h00;
    logic       d_plus, d_minus;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    logic [7:0] pkt[8];

    always #5 clk = ~clk;

    usb_d_orig_gen #(.CLKS_PER_BIT(CPB), .STUFF_LIMIT(6)) dut (
        .clk(clk), .n_rst(n_rst), .sending(sending), .data(data),
        .d_plus(d_plus), .d_minus(d_minus)
    );

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({d_plus, d_minus} !== e) begin
                errors++;
                $display("FAIL line t=%0t got=%b expected=%b", $time, {d_plus, d_minus}, e);
            end
        end
    end

    task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, got, want);
        end
    endtask

    task automatic step(input logic s, input logic [7:0] d, input logic [1:0] e);
        sending = s;
        data    = d;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // Reference: expand bytes into line bits (stuff after six ones), NRZI from J, then EOP symbols
    task automatic run_packet(input int nbytes, input int gap);
        logic [1:0] sym[$];
        int start_c[$];
        int ones, nbits, total, ki;
        logic [1:0] cur;
        logic b, s;
        cur  = J;
        ones = 0;
        for (int k = 0; k < nbytes; k++) begin
            start_c.push_back(sym.size() * CPB);
            for (int i = 0; i < 8; i++) begin
                b = pkt[k][i];
                if (!b) cur = (cur == J) ? K : J;
                sym.push_back(cur);
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    cur = (cur == J) ? K : J;
                    sym.push_back(cur);
                    ones = 0;
                end
            end
        end
        nbits = sym.size();
`ifdef D_ORIG_GEN_EOP_EN
        sym.push_back(SE0);
        sym.push_back(SE0);
        sym.push_back(J);
`endif
        total = sym.size() * CPB;
        ki = 0;
        for (int c = 0; c < total; c++) begin
            if (ki < nbytes && c == start_c[ki]) begin
                step(1'b1, pkt[ki], sym[c / CPB]);
                ki++;
            end else begin
                s = (c == nbits * CPB) ? 1'b0 : 1'($urandom);
                step(s, 8'($urandom), sym[c / CPB]);
            end
        end
        for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), J);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_idle", {d_plus, d_minus}, J);
        n_rst = 1'b0;
        step(1'b0, 8'h00, J);
        step(1'b0, 8'h00, J);
        chk("post_reset_idle", {d_plus, d_minus}, J);
        pkt[0] = 8'hFF; pkt[1] = 8'hFF;
        run_packet(2, 4);
        pkt[0] = 8'h00;
        run_packet(1, 3);
        pkt[0] = 8'hA5;
        run_packet(1, 1);
        pkt[0] = 8'h3F;
        run_packet(1, 5);
        pkt[0] = 8'h7E; pkt[1] = 8'hFC; pkt[2] = 8'h00;
        run_packet(3, 2);
        // Asynchronous abort mid-byte: line must be J before any clock edge
        step(1'b1, 8'h00, K);
        for (int c = 1; c < 20; c++) step(1'($urandom), 8'($urandom), ((c / CPB) % 2 == 0) ? K : J);
        n_rst = 1'b1;
        #1;
        chk("async_reset", {d_plus, d_minus}, J);
        exp_q.delete();
        for (int c = 0; c < 8; c++) step(1'b1, 8'($urandom), J);
        chk("reset_hold", {d_plus, d_minus}, J);
        n_rst = 1'b0;
        step(1'b0, 8'h00, J);
        for (int p = 0; p < 40; p++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) pkt[k] = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
            run_packet(n, $urandom_range(1, 6));
        end
        step(1'b0, 8'h00, J);
        @(posedge clk);
        #1;
        chk("queue_drained", 2'(exp_q.size()), 2'b00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
